ahb_sram_slave_p: RTL and testbench

- Parametrised AHB-Lite memory slave: the next-generation on-chip SRAM target for the AHB subsystem.
- Adds HSEL decode, proper address/data phase pipelining and configurable wait states.
- Adds HSIZE byte/halfword writes, HRESP two-cycle ERROR responses, and write-to-read forwarding.
- Sits behind the AHB interconnect decoder; the interconnect drives HREADY back to it.

---
 rtl/ahb_sram_slave_p.sv | 195 +++++++++++++++++++
 tb/tb_ahb_sram_slave_p.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_p.sv
// ahb_sram_slave_p: AHB-Lite SRAM slave with HSEL decode, pipelined
// address/data phases, configurable wait states, byte/halfword writes,
// two-cycle ERROR responses and write-to-read forwarding.
//
// Ports:
//   HCLK, HRESETn        clock (rising edge), async active-low reset
//   HSEL, HADDR, HTRANS  address-phase select, byte address, transfer type
//   HWRITE, HSIZE        direction and size (byte/halfword/word)
//   HWDATA               write data, sampled at the end of the data phase
//   HREADY               bus-level ready; address phase sampled only when 1
//   HREADYOUT, HRESP     slave ready and OKAY/ERROR response
//   HRDATA               full-word read data
module ahb_sram_slave_p #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Registered address-phase attributes of the transfer in its data phase
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic             write_q;
  logic [2:0]       size_q;

  logic [31:0]      mem [DEPTH];

  logic             accept_c;
  logic             take_c;
  logic             oor_c;
  logic             misalign_c;
  logic             err_c;
  logic             wr_fire_c;
  logic [3:0]       be_c;
  logic             nxt_write_c;
  logic [IDX_W-1:0] nxt_idx_c;
  logic             rd_load_c;
  logic [31:0]      rd_word_c;

  // Transfer request: NONSEQ or SEQ, selected, and bus ready
  assign accept_c = HSEL & HREADY & ((HTRANS == 2'b10) | (HTRANS == 2'b11));

  // Only states that end with HREADYOUT=1 may take a new address phase
  assign take_c = accept_c &
                  ((state == S_IDLE) | (state == S_DATA) | (state == S_ERR2));

  // Out-of-range: any address bit above the word index is set (no aliasing)
  if (ADDR_W > IDX_W + 2) begin : g_oor
    assign oor_c = |HADDR[ADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign oor_c = 1'b0;
  end

  assign misalign_c = ((HSIZE == 3'b001) & HADDR[0]) |
                      ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));
  assign err_c      = oor_c | (HSIZE > 3'b010) | misalign_c;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (take_c) begin
          if (err_c) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES - 1);
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Byte enables of the write in its data phase
  always_comb begin
    be_c = 4'b0000;
    case (size_q)
      3'b000:  be_c = 4'(4'b0001 << lane_q);
      3'b001:  be_c = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // A write commits at the edge that ends its DATA cycle
  assign wr_fire_c = (state == S_DATA) & write_q;

  // Attributes of the transfer that will occupy the next DATA cycle
  always_comb begin
    nxt_write_c = write_q;
    nxt_idx_c   = idx_q;
    if (take_c) begin
      nxt_write_c = HWRITE;
      nxt_idx_c   = HADDR[IDX_W+1:2];
    end
  end

  assign rd_load_c = (state_nxt == S_DATA) & ~nxt_write_c;

  // Read word, merged with the write committing at this same edge
  always_comb begin
    rd_word_c = mem[nxt_idx_c];
    if (wr_fire_c && (idx_q == nxt_idx_c)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) rd_word_c[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Memory array: not reset
  always_ff @(posedge HCLK) begin
    if (wr_fire_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Captured transfer attributes and registered bus outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q     <= '0;
      lane_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      if (take_c) begin
        idx_q   <= HADDR[IDX_W+1:2];
        lane_q  <= HADDR[1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      HREADYOUT <= ~((state_nxt == S_WAIT) | (state_nxt == S_ERR1));
      HRESP     <= (state_nxt == S_ERR1) | (state_nxt == S_ERR2);
      if (rd_load_c) begin
        HRDATA <= rd_word_c;
      end else if (state_nxt == S_ERR1) begin
        HRDATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave_p.sv
// Bench for ahb_sram_slave_p: two instances (0 and 3 wait states) driven by a
// pipelined AHB master; results compared with a byte-array memory model.
module tb_ahb_sram_slave_p;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    bit          idle;
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          use_exp;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];
  logic        force_lo  [2];

  logic [7:0]  mdl [2][DEPTH*4];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign hready[0] = force_lo[0] ? 1'b0 : hreadyout[0];
  assign hready[1] = force_lo[1] ? 1'b0 : hreadyout[1];

  ahb_sram_slave_p #(.DEPTH(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave_p #(.DEPTH(DEPTH), .WAIT_STATES(3), .ADDR_W(32)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the error rules
  function automatic bit model_err(input op_t o);
    if (o.size > 3'd2) return 1'b1;
    if ((o.addr >> 2) >= 32'(DEPTH)) return 1'b1;
    if ((o.addr % (32'd1 << o.size)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_err_of(input op_t o);
    return o.use_exp ? o.exp_err : model_err(o);
  endfunction

  task automatic model_write(input int d, input op_t o);
    int unsigned nb = 32'd1 << o.size;
    for (int unsigned k = 0; k < nb; k++) begin
      int unsigned b = o.addr + k;
      mdl[d][b] = o.wdata[8*(b%4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int unsigned w = a & ~32'd3;
    return {mdl[d][w+3], mdl[d][w+2], mdl[d][w+1], mdl[d][w]};
  endfunction

  function automatic op_t mk(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                             input logic [31:0] wd, input logic [31:0] er, input bit ee);
    op_t o;
    o.idle = 1'b0; o.sel = 1'b1; o.trans = 2'b10; o.addr = a; o.wr = wr;
    o.size = sz; o.wdata = wd; o.use_exp = 1'b1; o.exp_rdata = er; o.exp_err = ee;
    return o;
  endfunction

  function automatic op_t mk_m(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                               input logic [31:0] wd);
    op_t o = mk(a, wr, sz, wd, 32'd0, 1'b0);
    o.use_exp = 1'b0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o = mk_m(32'd0, 1'b0, 3'd2, 32'd0);
    int unsigned pick;
    o.wdata = $urandom;
    if ($urandom_range(0, 9) < 2) begin
      o.idle  = 1'b1;
      o.sel   = 1'($urandom_range(0, 1));
      o.trans = o.sel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      o.addr  = $urandom;
      o.wr    = 1'($urandom_range(0, 1));
      return o;
    end
    o.trans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    o.wr    = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                           : 3'($urandom_range(0, 2));
    pick = $urandom_range(0, 7);
    if (pick == 0)      o.addr = $urandom;
    else if (pick == 1) o.addr = 32'($urandom_range(32'h3E0, 32'h41F));
    else                o.addr = 32'($urandom_range(0, 32'h7F));
    if ($urandom_range(0, 4) != 0) o.addr = o.addr & ~((32'd1 << o.size[1:0]) - 32'd1);
    return o;
  endfunction

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0; hwrite[d] = 1'b0; hsize[d] = 3'd0;
  endtask

  task automatic drive_addr(input int d, input op_t o);
    hsel[d]   = o.idle ? o.sel : 1'b1;
    htrans[d] = o.trans;
    haddr[d]  = o.addr;
    hwrite[d] = o.wr;
    hsize[d]  = o.size;
  endtask

  // Checks at the last cycle of a data phase
  task automatic finish_dp(input int d, input op_t o, input int waits, input bit rbad);
    bit e;
    if (o.idle) begin
      check("idle_zero_wait", d, 32'(waits), 32'd0);
      check("idle_okay", d, 32'(hresp[d]), 32'd0);
      return;
    end
    e = exp_err_of(o);
    check("resp", d, 32'(hresp[d]), 32'(e));
    check("wait_cycles", d, 32'(waits), e ? 32'd1 : 32'(ws_of(d)));
    if (waits > 0) check("resp_in_wait", d, 32'(rbad), 32'd0);
    if (e) check("rdata_err", d, hrdata[d], 32'd0);
    else if (!o.wr)
      check(o.use_exp ? "rdata_vec" : "rdata_model", d, hrdata[d],
            o.use_exp ? o.exp_rdata : model_word(d, o.addr));
  endtask

  // Pipelined master: call and return at #1 after a rising edge
  task automatic run(input int d, input op_t ops[$]);
    op_t dp;
    bit  dp_v = 1'b0;
    bit  rdy;
    bit  rbad = 1'b0;
    int  waits = 0;
    int  i = 0;
    int  cyc = 0;
    int  limit = ops.size() * (ws_of(d) + 3) + 20;
    while (i < ops.size() || dp_v) begin
      if (i < ops.size()) drive_addr(d, ops[i]);
      else drive_idle(d);
      // HWDATA is garbage while the slave stalls; real data only in the last cycle
      if (dp_v && dp.wr && hreadyout[d]) hwdata[d] = dp.wdata;
      else hwdata[d] = $urandom;
      @(negedge clk);
      rdy = hready[d];
      if (dp_v) begin
        if (!hreadyout[d]) begin
          waits++;
          if (hresp[d] !== (dp.idle ? 1'b0 : exp_err_of(dp))) rbad = 1'b1;
        end else begin
          finish_dp(d, dp, waits, rbad);
        end
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (dp_v && !dp.idle && dp.wr && !exp_err_of(dp)) model_write(d, dp);
        dp_v = (i < ops.size());
        if (dp_v) begin
          dp = ops[i];
          i++;
        end
        waits = 0;
        rbad  = 1'b0;
      end
      cyc++;
      if (cyc > limit) begin
        check("run_timeout", d, 32'(cyc), 32'(limit));
        break;
      end
    end
    drive_idle(d);
  endtask

  op_t tbl[16];
  op_t q[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_idle(d); hwdata[d] = '0; force_lo[d] = 1'b0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_hreadyout", d, 32'(hreadyout[d]), 32'd1);
      check("rst_hresp", d, 32'(hresp[d]), 32'd0);
      check("rst_hrdata", d, hrdata[d], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    tbl[0]  = mk(32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    tbl[1]  = mk(32'h010, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    tbl[2]  = mk(32'h013, 1'b1, 3'd0, 32'h77000000, 32'h0, 1'b0);
    tbl[3]  = mk(32'h010, 1'b0, 3'd2, 32'h0, 32'h77ADBEEF, 1'b0);
    tbl[4]  = mk(32'h020, 1'b1, 3'd2, 32'h00000000, 32'h0, 1'b0);
    tbl[5]  = mk(32'h021, 1'b1, 3'd0, 32'h0000AA00, 32'h0, 1'b0);
    tbl[6]  = mk(32'h022, 1'b1, 3'd1, 32'h12340000, 32'h0, 1'b0);
    tbl[7]  = mk(32'h020, 1'b0, 3'd2, 32'h0, 32'h1234AA00, 1'b0);
    tbl[8]  = mk(32'h000, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0);
    tbl[9]  = mk(32'h400, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    tbl[10] = mk(32'h002, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1);
    tbl[11] = mk(32'h000, 1'b0, 3'd2, 32'h0, 32'h11223344, 1'b0);
    tbl[12] = mk(32'h001, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b1);
    tbl[13] = mk(32'h000, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1);
    tbl[14] = mk(32'h3FC, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0);
    tbl[15] = mk(32'h3FF, 1'b0, 3'd0, 32'h0, 32'hCAFEF00D, 1'b0);

    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int w = 0; w < int'(DEPTH); w++) q.push_back(mk_m(32'(w * 4), 1'b1, 3'd2, 32'd0));
      run(d, q);
      q.delete();
      foreach (tbl[k]) q.push_back(tbl[k]);
      run(d, q);
    end

    // HREADY held low by another slave: no accept, no memory change
    force_lo[0] = 1'b1;
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h40;
    hsize[0] = 3'd2; hwdata[0] = 32'h55AA55AA;
    repeat (3) begin
      @(negedge clk);
      check("hready_lo_no_accept", 0, 32'(hreadyout[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    force_lo[0] = 1'b0;
    drive_idle(0);
    @(negedge clk);
    check("hready_lo_okay", 0, 32'(hresp[0]), 32'd0);
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(mk(32'h40, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0));
    run(0, q);

    // Reset during the wait state of a write aborts it
    q.delete();
    q.push_back(mk_m(32'h44, 1'b0, 3'd2, 32'h0));
    q.push_back(mk_m(32'h44, 1'b1, 3'd2, 32'h600DF00D));
    q.push_back(mk_m(32'h44, 1'b0, 3'd2, 32'h0));
    run(1, q);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h44; hsize[1] = 3'd2;
    @(posedge clk);
    #1;
    drive_idle(1);
    hwdata[1] = 32'hBAD0BAD0;
    check("ws_entered", 1, 32'(hreadyout[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_hreadyout", 1, 32'(hreadyout[1]), 32'd1);
    check("rst_mid_hresp", 1, 32'(hresp[1]), 32'd0);
    check("rst_mid_hrdata", 1, hrdata[1], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(mk(32'h44, 1'b0, 3'd2, 32'h0, 32'h600DF00D, 1'b0));
    run(1, q);

    // Randomized traffic against the model
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int k = 0; k < 400; k++) q.push_back(rand_op());
      run(d, q);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
